// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads a combinational ROM and queues {inst, pc} pairs for decode.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_AW    = 6,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              halt_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              rom_ce_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [31:0]       rom_inst_i,
  output logic [31:0]       inst_o,
  output logic [31:0]       inst_pc_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt_o,
  output logic [31:0]       perf_full_cnt_o
`endif
);

  localparam int             PW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [CW-1:0]  ONE_C   = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [31:0]   r_pc;
  logic [31:0]   w_pc_next;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_rd_ptr_inc;
  logic [CW-1:0] r_count;

  logic [31:0]   r_mem_inst [BUF_DEPTH];
  logic [31:0]   r_mem_pc   [BUF_DEPTH];

  logic [31:0]   r_head_inst;
  logic [31:0]   r_head_pc;
  logic [31:0]   w_head_inst_next;
  logic [31:0]   w_head_pc_next;

  logic          w_full;
  logic          w_valid;
  logic          w_pop;
  logic          w_can_fetch;
  logic          w_unused;

  assign w_full       = (r_count == DEPTH_C);
  assign w_valid      = (r_count != '0) & ~redirect_i;
  assign w_pop        = w_valid & inst_ready_i;
  assign w_rd_ptr_inc = r_rd_ptr + PW'(1);
  assign w_unused     = &{1'b0, redirect_pc_i[1:0]};

  // ---------------------------------------------------------------------------
  // Control FSM: one dead IDLE cycle after reset, then FETCH until next reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_state_next = r_state;
    w_can_fetch  = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_next = FETCH;
      end
      FETCH: begin
        w_can_fetch = ~halt_i & ~redirect_i & (~w_full | w_pop);
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Redirect wins over everything, including the IDLE dead cycle.
  always_comb begin
    w_pc_next = r_pc;
    if (redirect_i) begin
      w_pc_next = {redirect_pc_i[31:2], 2'b00};
    end else if (w_can_fetch) begin
      w_pc_next = r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_can_fetch) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      case ({w_can_fetch, w_pop})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // observed through the head register after it has been written.
  always_ff @(posedge clk_i) begin
    if (w_can_fetch) begin
      r_mem_inst[r_wr_ptr] <= rom_inst_i;
      r_mem_pc[r_wr_ptr]   <= r_pc;
    end
  end

  // The head register mirrors the oldest entry and holds it once the FIFO
  // empties, so decode sees stable data while valid is low.
  always_comb begin
    w_head_inst_next = r_head_inst;
    w_head_pc_next   = r_head_pc;
    if (!redirect_i) begin
      if (w_can_fetch && ((r_count == '0) || (w_pop && (r_count == ONE_C)))) begin
        w_head_inst_next = rom_inst_i;
        w_head_pc_next   = r_pc;
      end else if (w_pop && (r_count > ONE_C)) begin
        w_head_inst_next = r_mem_inst[w_rd_ptr_inc];
        w_head_pc_next   = r_mem_pc[w_rd_ptr_inc];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head_inst <= '0;
      r_head_pc   <= '0;
    end else begin
      r_head_inst <= w_head_inst_next;
      r_head_pc   <= w_head_pc_next;
    end
  end

  assign rom_ce_o     = w_can_fetch;
  assign rom_addr_o   = r_pc[ROM_AW+1:2];
  assign inst_valid_o = w_valid;
  assign inst_o       = r_head_inst;
  assign inst_pc_o    = r_head_pc;

`ifdef FETCH_PERF_EN
  logic        w_full_stall;
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_full_cnt;

  assign w_full_stall = (r_state == FETCH) & ~halt_i & ~redirect_i & w_full & ~w_pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_fetch_cnt <= '0;
      r_perf_full_cnt  <= '0;
    end else begin
      if (w_can_fetch) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      if (w_full_stall) begin
        r_perf_full_cnt <= r_perf_full_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o = r_perf_fetch_cnt;
  assign perf_full_cnt_o  = r_perf_full_cnt;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed plus short random bench for fetch_ctrl; a queue scoreboard holds the
// entries decode should see, in order, and a small model predicts rom_ce/rom_addr.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          ROM_AW    = 6;
  localparam int          BUF_DEPTH = 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              halt_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic              rom_ce_o;
  logic [ROM_AW-1:0] rom_addr_o;
  logic [31:0]       rom_inst_i;
  logic [31:0]       inst_o;
  logic [31:0]       inst_pc_o;
  logic              inst_valid_o;
  logic              inst_ready_i;
`ifdef FETCH_PERF_EN
  logic [31:0]       perf_fetch_cnt_o;
  logic [31:0]       perf_full_cnt_o;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  entry_t      exp_q[$];
  logic [31:0] m_pc;
  logic        m_fetch;

  always #5 clk_i = ~clk_i;

  // ROM word k holds 32'h1000_0000 + k.
  assign rom_inst_i = 32'h1000_0000 + 32'(rom_addr_o);

  fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .ROM_AW   (ROM_AW),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .halt_i       (halt_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .rom_ce_o     (rom_ce_o),
    .rom_addr_o   (rom_addr_o),
    .rom_inst_i   (rom_inst_i),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt_o(perf_fetch_cnt_o),
    .perf_full_cnt_o (perf_full_cnt_o)
`endif
  );

  function automatic logic [31:0] rom_val(input logic [31:0] pc);
    return 32'h1000_0000 + 32'(pc[ROM_AW+1:2]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_ce"},   32'(rom_ce_o), 32'd0);
    check({tag, "_rom_addr"}, 32'(rom_addr_o), 32'(RESET_PC[ROM_AW+1:2]));
    check({tag, "_valid"},    32'(inst_valid_o), 32'd0);
    check({tag, "_inst"},     inst_o, 32'd0);
    check({tag, "_inst_pc"},  inst_pc_o, 32'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc    = RESET_PC;
    m_fetch = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge,
  // return 1 time unit later so the caller drives the next cycle's inputs.
  task automatic cycle();
    logic   valid_m;
    logic   pop_m;
    logic   can_m;
    entry_t e;
    @(negedge clk_i);
    valid_m = (exp_q.size() != 0) && !redirect_i;
    pop_m   = valid_m && inst_ready_i;
    can_m   = m_fetch && !halt_i && !redirect_i && ((exp_q.size() < BUF_DEPTH) || pop_m);
    check("rom_ce",   32'(rom_ce_o), 32'(can_m));
    check("rom_addr", 32'(rom_addr_o), 32'(m_pc[ROM_AW+1:2]));
    check("valid",    32'(inst_valid_o), 32'(valid_m));
    if (valid_m) begin
      check("inst",    inst_o, exp_q[0].inst);
      check("inst_pc", inst_pc_o, exp_q[0].pc);
    end
    @(posedge clk_i);
    if (redirect_i) begin
      exp_q.delete();
      m_pc = {redirect_pc_i[31:2], 2'b00};
    end else begin
      if (pop_m) void'(exp_q.pop_front());
      if (can_m) begin
        e.inst = rom_val(m_pc);
        e.pc   = m_pc;
        exp_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    m_fetch = 1'b1;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_i         = 1'b1;
    halt_i        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    inst_ready_i  = 1'b1;
    model_reset();

    // Reset state, then one dead cycle and a gap-free stream from RESET_PC.
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    rst_i = 1'b0;
    run(8);

    // Fill to two entries, then redirect to an unaligned target.
    inst_ready_i = 1'b0;
    run(3);
    check("fifo_full_before_redirect", 32'(exp_q.size()), 32'd2);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0023;
    cycle();
    redirect_i   = 1'b0;
    inst_ready_i = 1'b1;
    run(5);

    // Halt for 5 cycles with two entries buffered and decode accepting.
    inst_ready_i = 1'b0;
    run(3);
    halt_i       = 1'b1;
    inst_ready_i = 1'b1;
    run(5);
    check("halt_drained", 32'(exp_q.size()), 32'd0);
    halt_i = 1'b0;
    run(5);

    // PC wrap from FFFF_FFFC to 0.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    cycle();
    redirect_i = 1'b0;
    run(5);

    // Reset mid-stream: outputs forced at once, without waiting for an edge.
    rst_i = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i        = 1'b0;
    inst_ready_i = 1'b0;

    // Decode stalled from the start: IDLE cycle plus 10 FETCH cycles.
    run(11);
    check("stall_pc_held", 32'(rom_addr_o), 32'd2);
`ifdef FETCH_PERF_EN
    check("perf_fetch_cnt", perf_fetch_cnt_o, 32'd2);
    check("perf_full_cnt",  perf_full_cnt_o,  32'd8);
`endif
    inst_ready_i = 1'b1;
    run(6);

    // Mixed random traffic.
    for (int i = 0; i < 60; i++) begin
      inst_ready_i  = ($urandom_range(0, 3) != 0);
      halt_i        = ($urandom_range(0, 5) == 0);
      redirect_i    = ($urandom_range(0, 9) == 0);
      redirect_pc_i = $urandom;
      cycle();
    end
    redirect_i   = 1'b0;
    halt_i       = 1'b0;
    inst_ready_i = 1'b1;
    run(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch from the instruction ROM.
- Owns the PC and drives the ROM chip-enable and word address. The ROM is combinational and returns the instruction in the same cycle.
- Captures each instruction with its PC into a small FIFO, presented to decode over a valid/ready handshake.
- Handles halt requests and branch/jump redirects (redirects flush the FIFO).

Parameters:
- RESET_PC, 32'h0000_0000, byte PC loaded on reset.
- ROM_AW, 6, ROM word-address width; rom_addr_o = pc[ROM_AW+1:2].
- BUF_DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- halt_i  in  1  level; blocks new fetches; FIFO still drains.
- redirect_i  in  1  one-cycle pulse: flush FIFO, load PC.
- redirect_pc_i  in  32  target byte PC; bits [1:0] ignored (treated as 0).
- rom_ce_o  out  1  ROM chip-enable.
- rom_addr_o  out  ROM_AW  ROM word address.
- rom_inst_i  in  32  ROM data, valid in the same cycle as rom_ce_o.
- inst_o  out  32  instruction at FIFO head.
- inst_pc_o  out  32  PC of the FIFO head.
- inst_valid_o  out  1  FIFO head valid.
- inst_ready_i  in  1  decode accepts the head.

Behaviour:
- Reset (async, rst_i=1), all forced immediately:
  - state=IDLE, pc=RESET_PC, FIFO count=0, pointers=0.
  - rom_ce_o=0, rom_addr_o=RESET_PC[ROM_AW+1:2], inst_valid_o=0, inst_o=0, inst_pc_o=0.
- Reset mid-operation discards all buffered entries.
- States:
  - IDLE: rom_ce_o=0. Goes to FETCH on the first rising edge after rst_i deasserts. Gives exactly one dead cycle after reset.
  - FETCH: normal operation; never leaves FETCH except via reset.
- Terms:
  - pop = inst_valid_o & inst_ready_i & ~redirect_i.
  - can_fetch = FETCH & ~halt_i & ~redirect_i & (count < BUF_DEPTH | pop).
- rom_ce_o = can_fetch (combinational). rom_addr_o always reflects the current pc.
- On the edge with can_fetch=1:
  - write {rom_inst_i, pc} at the FIFO tail;
  - pc <= pc + 4. Wraps modulo 2^32: 32'hFFFF_FFFC -> 0.
- Fetch-to-decode latency is 1 cycle: the ROM is read in cycle N and the entry is visible at the head in N+1 if the FIFO was empty.
- Throughput is one instruction per cycle when decode accepts every cycle.
- FIFO:
  - inst_valid_o = (count != 0) & ~redirect_i.
  - inst_o and inst_pc_o come from the head register; they hold their values while inst_valid_o=0.
  - Simultaneous push and pop: count unchanged.
  - Full with no pop: no fetch, pc held.
  - Empty: no pop possible.
  - Pointers wrap modulo BUF_DEPTH.
- Redirect (redirect_i=1 on an edge):
  - count <= 0, pointers <= 0;
  - pc <= {redirect_pc_i[31:2], 2'b00};
  - no push and no pop that cycle.
  - Redirect has priority over halt, push and pop.
  - The fetch from the new PC happens in the next cycle (if not halted). Redirect-to-valid latency is 2 cycles.
- Redirect during IDLE: pc is loaded; the transition to FETCH still occurs.
- Halt:
  - pc is frozen while halted; decode may continue popping existing entries.
  - Deasserting halt resumes fetching from the frozen pc in the same cycle.
- Handshake: the entry at the head of the FIFO stays stable until popped; decode may hold inst_ready_i low indefinitely.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - adds output perf_fetch_cnt_o [31:0], incremented on every edge with can_fetch=1;
  - adds output perf_full_cnt_o [31:0], incremented on every FETCH edge with ~halt_i & ~redirect_i & FIFO full & ~pop;
  - both reset to 0 asynchronously and wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Release reset, inst_ready_i=1, ROM word k = 32'h1000_0000+k:
  - rom_ce_o=0 for one cycle;
  - then valid entries (pc 0, inst 1000_0000), (pc 4, inst 1000_0001), ..., one per cycle, no gaps.
- inst_ready_i=0 from the start, BUF_DEPTH=2:
  - exactly two fetches (pc 0, 4), then rom_ce_o=0 and pc held at 8;
  - raise ready: pops and refills continue back-to-back with no bubble.
- Redirect to 32'h0000_0023 while the FIFO holds 2 entries:
  - next cycle inst_valid_o=0, count=0;
  - ROM address 8 (pc 0x20) issued;
  - head (pc 0x20) valid 2 cycles after the redirect.
- halt_i=1 for 5 cycles with 2 entries buffered and ready=1:
  - both entries drain, no rom_ce_o, pc frozen;
  - on release, fetch resumes at the frozen pc.
- Redirect to 0xFFFF_FFFC: entry pc FFFF_FFFC is followed by entry pc 0. Assert rst_i mid-stream: outputs zero immediately, then restart at RESET_PC.
- With FETCH_PERF_EN, ready held 0 for 10 FETCH cycles: perf_fetch_cnt_o=2, perf_full_cnt_o=8.
